packet_fifo: RTL and testbench
==============================

Name: packet_fifo

Overview:
- Single-clock, show-behind (registered-output) FIFO that queues 32-bit packet words for one switch input port.
- One instance per input port. Words are written from the Avalon write decode (one `wrreq` pulse per bus write) and drained by the scheduler/buffer logic via `rdreq`.
- Drop-in replacement for the existing per-port FIFO: same data and flag semantics, plus a synchronous reset and error pulses.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, number of storage entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH) = 2, width of pointers and of `usedw`.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- data  in  WIDTH  write data, sampled on the clock edge when `wrreq` is accepted.
- wrreq  in  1  write request; one word per cycle while high.
- rdreq  in  1  read request; one word per cycle while high.
- q  out  WIDTH  registered read data.
- empty  out  1  high when the FIFO holds 0 words.
- full  out  1  high when the FIFO holds DEPTH words.
- usedw  out  AW  occupancy count modulo DEPTH (reads 0 when full).
- overflow  out  1  one-cycle pulse: `wrreq` was rejected because the FIFO was full.
- underflow  out  1  one-cycle pulse: `rdreq` was rejected because the FIFO was empty.

Behaviour:
- Reset (synchronous, when `reset`=1 at a clock edge):
  - Pointers and count cleared.
  - `q`=0, `empty`=1, `full`=0, `usedw`=0, `overflow`=0, `underflow`=0.
  - Reset wins over any simultaneous `wrreq`/`rdreq`.
  - Stored array contents need not be cleared.
- Internal count has AW+1 bits (range 0..DEPTH).
  - `usedw` = count[AW-1:0].
  - `full` = (count==DEPTH).
  - `empty` = (count==0).
  - All three are registered and derived from the post-edge count, so they update on the same edge as the accepted operation.
- Write acceptance: wr_ok = `wrreq` && !`full` (flag value before the edge).
  - On wr_ok: mem[wptr] <= `data`, then wptr increments modulo DEPTH.
- Read acceptance: rd_ok = `rdreq` && !`empty` (flag value before the edge).
  - On rd_ok: `q` <= mem[rptr], then rptr increments modulo DEPTH.
  - Latency: data appears on `q` the cycle after the `rdreq` edge.
  - `q` holds its value when no read is accepted.
- Simultaneous requests:
  - wr_ok and rd_ok together: count unchanged, both pointers advance.
  - Full with both requested: the write is rejected (`overflow` pulses) and the read proceeds; count goes DEPTH-1.
  - Empty with both requested: the read is rejected (`underflow` pulses, `q` unchanged) and the write proceeds; count goes to 1.
  - There is no write-through to `q` when empty.
- Rejected operations leave pointers, count, memory and `q` unchanged.
- `overflow` and `underflow` are registered single-cycle pulses, one per rejected request cycle.
- Pointers wrap from DEPTH-1 to 0 with no gap; ordering is strict FIFO across wrap-around.
- No combinational path from inputs to outputs.

Decomposition:
- Package `switch_pkg`:
  - WORD_W=32.
  - PORT_FIFO_DEPTH=4.
  - typedef `word_t` = logic [WORD_W-1:0].
  - Shared with the scheduler, buffer and display blocks.
- One natural sub-module, `fifo_ram`:
  - DEPTH x WIDTH register array with one write port and one registered read port (`wen`, `waddr`, `wdata`, `ren`, `raddr`, `rdata`).
  - Lets FPGA builds map it to block RAM.
- Pointer, count and flag logic stays in `packet_fifo`.

Test Plan:
- Reset then idle → `empty`=1, `full`=0, `usedw`=0, `q`=0; assert `rdreq` for 1 cycle → `underflow`=1 for exactly 1 cycle, `q` stays 0.
- Write 0x11111111, 0x22222222, 0x33333333 → `usedw` 1,2,3 on successive edges; then read 3 times → `q` = 0x11111111, 0x22222222, 0x33333333, each 1 cycle after its `rdreq`, and `empty`=1 after the third read.
- Write 4 words (0xA0..0xA3) → `full`=1, `usedw`=0; write a 5th word 0xFF → `overflow` pulses, and a drain returns 0xA0..0xA3 with no 0xFF.
- Full FIFO with `wrreq`=`rdreq`=1 for 1 cycle → `q`=0xA0, count 3 (`usedw`=3, `full`=0), `overflow`=1; empty FIFO with both requested and data=0x55 → `underflow`=1, `usedw`=1, and the next read returns 0x55.
- Streaming: hold `wrreq`=`rdreq`=1 for 10 cycles after 1 preload, data incrementing from 1 → `usedw` constant at 1, `q` outputs 1,2,3,... in order across pointer wrap.
- Assert `reset` mid-operation with 3 words stored and `wrreq`=1 → next cycle `empty`=1, `usedw`=0, `q`=0, and the subsequent first read after one write returns the new word only.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: word width, per-port FIFO depth and the word
// type used by the FIFO, scheduler, buffer and display blocks. Also holds
// the FIFO operation encoding used to update the occupancy count.
package switch_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned PORT_FIFO_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Accepted operations in one cycle, encoded as {write_ok, read_ok}.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage for packet_fifo: one write port, one registered read
// port. The read register has a synchronous clear so it can double as the
// FIFO output register and still map onto block RAM output registers.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous clear of rdata only (array is not cleared)
//   wen/waddr/wdata  write port
//   ren/raddr    read port; rdata updates on the edge where ren is high
//   rdata        registered read data, holds when ren is low
module fifo_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)    rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/packet_fifo.sv
// Per-port show-behind packet FIFO. Words written with wrreq are returned on
// q one cycle after the accepting rdreq edge. Flags and usedw are registered
// from the post-edge occupancy; overflow/underflow pulse for one cycle per
// rejected request.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   data, wrreq       write data and request (rejected when full)
//   rdreq             read request (rejected when empty)
//   q                 registered read data, holds when no read is accepted
//   empty, full       occupancy flags
//   usedw             occupancy modulo DEPTH (0 when full)
//   overflow          rejected write pulse
//   underflow         rejected read pulse
module packet_fifo
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = PORT_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [AW-1:0]    usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_ok;
  logic          rd_ok;
  fifo_op_e      op;

  assign wr_ok = wrreq && !full;
  assign rd_ok = rdreq && !empty;
  assign op    = fifo_op_e'({wr_ok, rd_ok});
  assign usedw = count[AW-1:0];

  always_comb begin
    count_nxt = count;
    unique case (op)
      OP_WR:   count_nxt = count + (AW+1)'(1);
      OP_RD:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == FULL_CNT);
      overflow  <= wrreq && full;
      underflow <= rdreq && empty;
    end
  end

  // Memory ports are masked during reset so reset wins over a concurrent
  // request; the RAM's read register is q itself, giving the one-cycle
  // show-behind latency without an extra stage.
  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .wen   (wr_ok && !reset),
    .waddr (wptr),
    .wdata (data),
    .ren   (rd_ok && !reset),
    .raddr (rptr),
    .rdata (q)
  );

endmodule

// File: tb/tb_packet_fifo.sv
module tb_packet_fifo;
  import switch_pkg::*;

  localparam int unsigned DEPTH = PORT_FIFO_DEPTH;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  word_t         data  = '0;
  word_t         q;
  logic          empty;
  logic          full;
  logic [AW-1:0] usedw;
  logic          overflow;
  logic          underflow;

  always #5 clock = ~clock;

  packet_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .wrreq     (wrreq),
    .rdreq     (rdreq),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .usedw     (usedw),
    .overflow  (overflow),
    .underflow (underflow)
  );

  int    checks = 0;
  int    errors = 0;

  // Reference model: a queue of stored words plus the expected output state.
  word_t mq[$];
  word_t m_q  = '0;
  bit    m_ov = 1'b0;
  bit    m_un = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input bit rd, input word_t d);
    bit was_full;
    bit was_empty;
    reset = rst;
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_q  = '0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_ov = wr && was_full;
      m_un = rd && was_empty;
      if (rd && !was_empty) m_q = mq.pop_front();
      if (wr && !was_full)  mq.push_back(d);
    end
    #1;
    check("q",         q,         m_q);
    check("empty",     empty,     mq.size() == 0);
    check("full",      full,      mq.size() == DEPTH);
    check("usedw",     usedw,     mq.size() % DEPTH);
    check("overflow",  overflow,  m_ov);
    check("underflow", underflow, m_un);
  endtask

  initial begin
    // Reset then idle
    step(1, 0, 0, '0);
    step(1, 1, 1, 32'hDEADBEEF);
    step(0, 0, 0, '0);
    check("rst_q", q, 32'h0);
    check("rst_empty", empty, 1'b1);
    step(0, 0, 1, '0);
    check("uf_pulse", underflow, 1'b1);
    step(0, 0, 0, '0);
    check("uf_one_cycle", underflow, 1'b0);

    // Three writes then three reads
    step(0, 1, 0, 32'h11111111);
    step(0, 1, 0, 32'h22222222);
    step(0, 1, 0, 32'h33333333);
    check("usedw3", usedw, 3);
    step(0, 0, 1, '0); check("rd1", q, 32'h11111111);
    step(0, 0, 1, '0); check("rd2", q, 32'h22222222);
    step(0, 0, 1, '0); check("rd3", q, 32'h33333333);
    check("empty_after3", empty, 1'b1);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hA0 + i);
    check("full4", full, 1'b1);
    check("usedw_full", usedw, 0);
    step(0, 1, 0, 32'hFF);
    check("of_pulse", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, '0);
      check("drain", q, 32'hA0 + i);
    end

    // Both requested when full, then when empty
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hA0 + i);
    step(0, 1, 1, 32'hEE);
    check("full_both_q", q, 32'hA0);
    check("full_both_usedw", usedw, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    step(0, 1, 1, 32'h55);
    check("empty_both_uf", underflow, 1'b1);
    check("empty_both_usedw", usedw, 1);
    step(0, 0, 1, '0);
    check("empty_both_rd", q, 32'h55);

    // Streaming across wrap
    step(0, 1, 0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 32'(i + 2));
      check("stream_q", q, 32'(i + 1));
      check("stream_usedw", usedw, 1);
    end
    step(0, 0, 1, '0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'hC0 + i);
    step(1, 1, 0, 32'hBAD);
    check("midrst_empty", empty, 1'b1);
    check("midrst_q", q, 32'h0);
    step(0, 1, 0, 32'h77);
    step(0, 0, 1, '0);
    check("midrst_rd", q, 32'h77);

    // Randomized traffic with phases of different write/read bias
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      int unsigned rp;
      wp = (i / 500) % 3 == 0 ? 70 : ((i / 500) % 3 == 1 ? 30 : 50);
      rp = 100 - wp;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < rp,
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
